// File: rtl/dm_store_buffer.sv
// In-order store FIFO between MEM stage and DM write port, with per-byte load forwarding.
// Ports: st_* (store in), ld_* (forward lookup), dm_* (drain to DM), empty/count. Option: STB_MERGE_EN.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_be,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  input  logic [31:0]      ld_addr,
  output logic [3:0]       ld_hit_be,
  output logic [31:0]      ld_data,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_pc,
  input  logic             dm_ready,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] tail_m1;
  logic             deq;
  logic             merge_ok;
  logic             acc;
  logic             do_merge;
  logic             do_alloc;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dm_we   = !empty;
  assign deq     = dm_we && dm_ready;
  assign tail_m1 = tail_q - 1'b1;

`ifdef STB_MERGE_EN
  // Merge into the youngest entry unless it is leaving this cycle.
  assign merge_ok = !empty && (st_be != 4'b0000)
                 && (addr_q[tail_m1] == st_addr[31:2])
                 && !((tail_m1 == head_q) && deq);
`else
  assign merge_ok = 1'b0;
`endif

  assign st_ready = (count_q != (PTR_W+1)'(DEPTH)) || merge_ok;
  assign acc      = st_valid && st_ready && (st_be != 4'b0000);
  assign do_merge = acc && merge_ok;
  assign do_alloc = acc && !merge_ok;

  assign dm_addr = dm_we ? {addr_q[head_q], 2'b00} : '0;
  assign dm_wd   = dm_we ? data_q[head_q] : '0;
  assign dm_be   = dm_we ? be_q[head_q]   : '0;
  assign dm_pc   = dm_we ? pc_q[head_q]   : '0;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(deq);
    if (do_merge) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) data_d[tail_m1][8*i +: 8] = st_data[8*i +: 8];
      end
      be_d[tail_m1] = be_q[tail_m1] | st_be;
      pc_d[tail_m1] = st_pc;
    end
    if (do_alloc) begin
      addr_d[tail_q]  = st_addr[31:2];
      data_d[tail_q]  = st_data;
      be_d[tail_q]    = st_be;
      pc_d[tail_q]    = st_pc;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
  end

  // Walk oldest to youngest so younger hits overwrite older lanes.
  always_comb begin
    logic [PTR_W-1:0] idx;
    ld_hit_be = '0;
    ld_data   = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (valid_q[idx] && (addr_q[idx] == ld_addr[31:2])) begin
        for (int i = 0; i < 4; i++) begin
          if (be_q[idx][i]) begin
            ld_hit_be[i]      = 1'b1;
            ld_data[8*i +: 8] = data_q[idx][8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: vector table plus directed
// multi-cycle sequences (fill/block, wrap, zero-be, async reset, merge).
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef STB_MERGE_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_addr, st_data, st_pc;
  logic [3:0]       st_be;
  logic             st_ready;
  logic [31:0]      ld_addr;
  logic [3:0]       ld_hit_be;
  logic [31:0]      ld_data;
  logic             dm_we;
  logic [31:0]      dm_addr, dm_wd, dm_pc;
  logic [3:0]       dm_be;
  logic             dm_ready;
  logic             empty;
  logic [PTR_W:0]   count;

  int total = 0;
  int bad   = 0;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_be(st_be), .st_pc(st_pc), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit_be(ld_hit_be), .ld_data(ld_data),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be),
    .dm_pc(dm_pc), .dm_ready(dm_ready), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [3:0]  sbe;
    logic        dr;
    logic [31:0] la;
    logic [3:0]  e_hit;
    logic [31:0] e_ld;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_we;
    logic [31:0] e_da;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_be    = '0;
    st_pc    = '0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = pc;
    tick();
    idle();
  endtask

  task automatic drain;
    idle();
    dm_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (empty) break;
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    logic [31:0] lg [$];
    logic [31:0] a;
    bit          sent;
    bit          acc;

    idle();
    reset    = 1'b0;
    dm_ready = 1'b0;
    ld_addr  = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_we", 32'(dm_we), 32'd0);

    //       sv  sa      sd            sbe  dr  la
    //       hit  ld  rdy cnt we da wd be
    tbl[0] = '{1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h20,
               4'h0, 32'h0, 1'b1, 3'd1, 1'b1, 32'h20, 32'h11223344, 4'hF};
    tbl[1] = '{1'b1, 32'h20, 32'hAABBCCDD, 4'h3, 1'b0, 32'h22,
               4'hF, 32'h11223344, 1'b1, M ? 3'd1 : 3'd2, 1'b1, 32'h20,
               M ? 32'h1122CCDD : 32'h11223344, 4'hF};
    tbl[2] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h22,
               4'hF, 32'h1122CCDD, 1'b1, M ? 3'd1 : 3'd2, 1'b1, 32'h20,
               M ? 32'h1122CCDD : 32'h11223344, 4'hF};
    tbl[3] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h24,
               4'h0, 32'h0, 1'b1, M ? 3'd1 : 3'd2, 1'b1, 32'h20,
               M ? 32'h1122CCDD : 32'h11223344, 4'hF};
    tbl[4] = '{1'b1, 32'h30, 32'h55667788, 4'hC, 1'b0, 32'h30,
               4'h0, 32'h0, 1'b1, M ? 3'd2 : 3'd3, 1'b1, 32'h20,
               M ? 32'h1122CCDD : 32'h11223344, 4'hF};
    tbl[5] = '{1'b1, 32'h40, 32'hDEADBEEF, 4'h0, 1'b0, 32'h30,
               4'hC, 32'h55660000, 1'b1, M ? 3'd2 : 3'd3, 1'b1, 32'h20,
               M ? 32'h1122CCDD : 32'h11223344, 4'hF};
    tbl[6] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20,
               4'hF, 32'h1122CCDD, 1'b1, M ? 3'd1 : 3'd2, 1'b1,
               M ? 32'h30 : 32'h20, M ? 32'h55667788 : 32'hAABBCCDD,
               M ? 4'hC : 4'h3};
    tbl[7] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20,
               M ? 4'h0 : 4'h3, M ? 32'h0 : 32'h0000CCDD, 1'b1,
               M ? 3'd0 : 3'd1, M ? 1'b0 : 1'b1, M ? 32'h0 : 32'h30,
               M ? 32'h0 : 32'h55667788, M ? 4'h0 : 4'hC};
    tbl[8] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h30,
               M ? 4'h0 : 4'hC, M ? 32'h0 : 32'h55660000, 1'b1,
               3'd0, 1'b0, 32'h0, 32'h0, 4'h0};

    for (int i = 0; i < 9; i++) begin
      st_valid = tbl[i].sv;
      st_addr  = tbl[i].sa;
      st_data  = tbl[i].sd;
      st_be    = tbl[i].sbe;
      st_pc    = 32'h1000 + tbl[i].sa;
      dm_ready = tbl[i].dr;
      ld_addr  = tbl[i].la;
      #1;
      chk($sformatf("v%0d_hit", i), 32'(ld_hit_be), 32'(tbl[i].e_hit));
      chk($sformatf("v%0d_ld", i), ld_data, tbl[i].e_ld);
      chk($sformatf("v%0d_rdy", i), 32'(st_ready), 32'(tbl[i].e_rdy));
      tick();
      chk($sformatf("v%0d_cnt", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_we", i), 32'(dm_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_da", i), dm_addr, tbl[i].e_da);
      chk($sformatf("v%0d_wd", i), dm_wd, tbl[i].e_wd);
      chk($sformatf("v%0d_be", i), 32'(dm_be), 32'(tbl[i].e_be));
    end
    drain();

    // Fill and block, then drain in order with the held 5th store.
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      put(a, 32'hA000 + a, 4'hF, 32'h2000 + a);
    end
    chk("fill_cnt", 32'(count), 32'd4);
    st_valid = 1'b1;
    st_addr  = 32'h10;
    st_data  = 32'hA010;
    st_be    = 4'hF;
    st_pc    = 32'h2010;
    #1;
    chk("fill_rdy0", 32'(st_ready), 32'd0);
    tick();
    chk("fill_held", 32'(count), 32'd4);
    dm_ready = 1'b1;
    #1;
    chk("full_nopass", 32'(st_ready), 32'd0);
    lg.delete();
    sent = 1'b0;
    for (int c = 0; c < 20; c++) begin
      st_valid = !sent;
      #1;
      if (dm_we && dm_ready) lg.push_back(dm_addr);
      acc = st_valid && st_ready;
      tick();
      if (acc) sent = 1'b1;
      if (sent && empty) break;
    end
    idle();
    chk("fill_n", 32'(lg.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fill_ord%0d", k),
          (k < lg.size()) ? lg[k] : 32'hFFFF_FFFF, 32'(4 * k));
    end
    drain();

    // Simultaneous enqueue/dequeue across pointer wrap.
    dm_ready = 1'b0;
    put(32'h100, 32'h100, 4'hF, 32'h0);
    put(32'h104, 32'h104, 4'hF, 32'h0);
    chk("sim_cnt0", 32'(count), 32'd2);
    dm_ready = 1'b1;
    lg.delete();
    for (int i = 0; i < 8; i++) begin
      st_valid = 1'b1;
      st_addr  = 32'h108 + 32'(4 * i);
      st_data  = st_addr;
      st_be    = 4'hF;
      #1;
      if (dm_we) lg.push_back(dm_addr);
      tick();
      chk($sformatf("sim_cnt%0d", i + 1), 32'(count), 32'd2);
    end
    idle();
    for (int c = 0; c < 10; c++) begin
      if (empty) break;
      #1;
      if (dm_we) lg.push_back(dm_addr);
      tick();
    end
    chk("sim_n", 32'(lg.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("sim_ord%0d", k),
          (k < lg.size()) ? lg[k] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * k));
    end
    drain();

    // Zero byte enable is accepted but stores nothing.
    st_valid = 1'b1;
    st_addr  = 32'h200;
    st_data  = 32'h12345678;
    st_be    = 4'h0;
    #1;
    chk("zbe_rdy", 32'(st_ready), 32'd1);
    tick();
    idle();
    chk("zbe_cnt", 32'(count), 32'd0);
    chk("zbe_we", 32'(dm_we), 32'd0);

    // Asynchronous reset mid-operation.
    dm_ready = 1'b0;
    put(32'h300, 32'h3000, 4'hF, 32'h3300);
    put(32'h304, 32'h3004, 4'hF, 32'h3304);
    put(32'h308, 32'h3008, 4'hF, 32'h3308);
    chk("arst_pre", 32'(count), 32'd3);
    ld_addr = 32'h304;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_we", 32'(dm_we), 32'd0);
    chk("arst_rdy", 32'(st_ready), 32'd1);
    chk("arst_hit", 32'(ld_hit_be), 32'd0);
    tick();
    reset = 1'b1;
    put(32'h10, 32'hCAFE0010, 4'hF, 32'h4444);
    chk("arst_we1", 32'(dm_we), 32'd1);
    chk("arst_da", dm_addr, 32'h10);
    chk("arst_wd", dm_wd, 32'hCAFE0010);
    chk("arst_pc", dm_pc, 32'h4444);
    drain();

    // Same-word back-to-back stores (merged only when enabled).
    dm_ready = 1'b0;
    put(32'h40, 32'h000000AA, 4'b0001, 32'h500);
    put(32'h40, 32'h0000BB00, 4'b0010, 32'h504);
    chk("mrg_cnt", 32'(count), M ? 32'd1 : 32'd2);
    chk("mrg_wd", dm_wd, M ? 32'h0000BBAA : 32'h000000AA);
    chk("mrg_be", 32'(dm_be), M ? 32'd3 : 32'd1);
    chk("mrg_pc", dm_pc, M ? 32'h504 : 32'h500);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Small in-order store FIFO between the CPU's memory-access stage and the data memory's write port.
- Accepts word/byte-masked stores and drains them one per cycle to DM, decoupling store issue from DM write acceptance.
- Provides combinational per-byte load forwarding, so loads see pending stores before they reach DM.

Parameters:
DEPTH, 4, number of buffered entries; power of two, >= 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
st_valid  input  1  store request this cycle
st_addr  input  32  store byte address; bits [1:0] ignored
st_data  input  32  store data, byte lanes aligned to word
st_be  input  4  byte enables, bit i = byte i (bits [8i+7:8i])
st_pc  input  32  PC of the store, carried for DM trace display
st_ready  output  1  buffer can accept a store this cycle
ld_addr  input  32  load byte address for forwarding lookup
ld_hit_be  output  4  bytes of ld_addr's word covered by buffered stores
ld_data  output  32  forwarded bytes; uncovered lanes read 0
dm_we  output  1  head entry valid and presented to DM
dm_addr  output  32  head word address, {addr[31:2],2'b00}
dm_wd  output  32  head data
dm_be  output  4  head byte enables
dm_pc  output  32  head PC
dm_ready  input  1  DM accepts head this cycle
empty  output  1  no entries buffered
count  output  PTR_W+1  number of entries buffered

Behaviour:
- Reset (reset=0, asynchronous): head/tail pointers and count cleared; all entry valid state cleared. Outputs: empty=1, count=0, st_ready=1, dm_we=0, ld_hit_be=0. Clearing takes effect immediately, not at the next edge. Any in-flight enqueue or dequeue is discarded.
- Storage per entry: word address (30 b), data (32 b), be (4 b), pc (32 b).
- st_ready = (count != DEPTH). There is no pass-through when full, even if a dequeue happens in the same cycle.
- Enqueue when st_valid && st_ready:
  - writes the entry at tail; tail wraps modulo DEPTH.
  - st_be == 4'b0000 is accepted but not stored (no-op); count is unchanged.
- Drain:
  - dm_we = !empty; dm_* are driven combinationally from the head entry.
  - Dequeue on an edge where dm_we && dm_ready; head wraps modulo DEPTH.
  - When empty, dm_addr, dm_wd, dm_be and dm_pc are 0.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Latency: a store accepted at edge N appears on dm_* after edge N, so it can be written to DM at edge N+1 at the earliest.
- Forwarding (combinational):
  - For each byte lane i, select the youngest valid entry whose word address equals ld_addr[31:2] and whose be[i]=1.
  - ld_hit_be[i] = 1 if such an entry exists; ld_data lane i comes from that entry.
  - The head entry being dequeued this cycle still participates in forwarding.
  - A store being enqueued this cycle does not participate.
- Ordering: strictly FIFO. DM never sees stores out of order, and never sees the same entry twice.

Optional Feature:
- Macro: STB_MERGE_EN.
- Defined:
  - An enqueue whose word address equals the tail-most valid entry's word address merges into that entry: data lanes with st_be set are overwritten and be |= st_be.
  - No new entry is allocated and count is unchanged.
  - Merging is suppressed if that entry is the head and is being dequeued this cycle; a new entry is allocated instead.
  - A merge is allowed when full (st_ready=1 if a merge would occur).
  - dm_pc of a merged entry is the PC of the latest store.
- Undefined: every accepted store with st_be != 0 allocates its own entry.

Test Plan:
- Reset mid-operation: load 3 entries, pull reset low between edges -> empty=1, count=0, dm_we=0, st_ready=1 immediately; after release, a new store to 0x10 is the first thing presented on dm_*.
- Fill and block: dm_ready=0, issue 5 stores 0x00..0x10 (be=4'hF) -> first 4 accepted, count=4, st_ready=0, 5th held. Then dm_ready=1 -> dm_addr sequence 0x00, 0x04, 0x08, 0x0C, then 0x10.
- Forwarding priority: dm_ready=0; store 0x20 data 0x11223344 be=F, then store 0x20 data 0xAABBCCDD be=4'b0011; ld_addr=0x22 -> ld_hit_be=4'hF, ld_data=0x1122CCDD. Load 0x24 -> ld_hit_be=0, ld_data=0.
- Simultaneous enqueue/dequeue: count=2, dm_ready=1, st_valid=1 -> count stays 2; order preserved across pointer wrap after 8 consecutive cycles.
- Zero byte enable: st_be=0 with st_valid=1 -> st_ready=1, count unchanged, nothing reaches dm_*.
- STB_MERGE_EN: dm_ready=0; store 0x40 data 0x000000AA be=0001, then 0x40 data 0x0000BB00 be=0010 -> count=1, dm_wd=0x0000BBAA, dm_be=4'b0011. Without the macro: count=2.
